// File: rtl/stk_pipe_rsp.sv
// Response stage of the stack pipeline: captures WB results into per-engine slots,
// hands them to engines on valid/ack, and pulses AD to clear the engine's active bit.

module stk_rsp_slot #(
  parameter int                   OPCODE_W = 2,
  parameter int                   DAT_W    = 128,
  parameter logic [OPCODE_W-1:0]  OP_NOP   = '0,
  parameter logic [OPCODE_W-1:0]  OP_POP   = OPCODE_W'(2)
)(
  input  logic                clk,
  input  logic                rst,
  input  logic                wb_sel,
  input  logic [OPCODE_W-1:0] wb_opcode,
  input  logic [1:0]          wb_status,
  input  logic [DAT_W-1:0]    wb_dat,
  input  logic                ack,
  output logic                vld,
  output logic [OPCODE_W-1:0] opcode,
  output logic [1:0]          status,
  output logic [DAT_W-1:0]    dat,
  output logic                ad_pulse,
  output logic                inc,
  output logic                dec,
  output logic                ovf
);
  typedef enum logic {IDLE, PEND} state_t;
  state_t state;

  logic pend, ack_v, load;

  assign pend     = (state == PEND);
  assign vld      = pend;
  assign ack_v    = pend & ack;
  // A WB may land in an idle slot or in one being acked this same cycle
  assign load     = wb_sel & (~pend | ack);
  assign ad_pulse = ack_v & ~rst;
  assign inc      = load & ~pend;
  assign dec      = ack_v & ~load;
  assign ovf      = wb_sel & pend & ~ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      opcode <= OP_NOP;
      status <= 2'd0;
      dat    <= '0;
    end else if (load) begin
      state  <= PEND;
      opcode <= wb_opcode;
      status <= wb_status;
      dat    <= (wb_opcode == OP_POP && wb_status == 2'd0) ? wb_dat : '0;
    end else if (ack_v) begin
      state  <= IDLE;
    end
  end
endmodule

module stk_pipe_rsp #(
  parameter int                   ENGS_N   = 4,
  parameter int                   DAT_W    = 128,
  parameter int                   OPCODE_W = 2,
  parameter logic [OPCODE_W-1:0]  OP_NOP   = '0,
  parameter logic [OPCODE_W-1:0]  OP_POP   = OPCODE_W'(2),
  localparam int                  ENGID_W  = (ENGS_N > 1) ? $clog2(ENGS_N) : 1
)(
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_wb_vld,
  input  logic [ENGID_W-1:0]               i_wb_engid,
  input  logic [OPCODE_W-1:0]              i_wb_opcode,
  input  logic [1:0]                       i_wb_status,
  input  logic [DAT_W-1:0]                 i_wb_dat,
  output logic [ENGS_N-1:0]                o_rsp_vld,
  output logic [ENGS_N-1:0][OPCODE_W-1:0]  o_rsp_opcode,
  output logic [ENGS_N-1:0][1:0]           o_rsp_status,
  output logic [ENGS_N-1:0][DAT_W-1:0]     o_rsp_dat,
  input  logic [ENGS_N-1:0]                i_rsp_ack,
  output logic [ENGS_N-1:0]                o_ad_rsp_vld,
  output logic [ENGID_W:0]                 o_pend_cnt,
  output logic                             o_err_ovf,
  output logic                             o_err_op
);
  localparam int CNT_W = ENGID_W + 1;

  logic              op_ok;
  logic [ENGS_N-1:0] wb_sel, inc, dec, ovf;
  logic [CNT_W-1:0]  cnt_nxt;

  assign op_ok = i_wb_vld & (i_wb_opcode != OP_NOP) & (i_wb_status != 2'd3);

  for (genvar e = 0; e < ENGS_N; e++) begin : g_slot
    assign wb_sel[e] = op_ok & (i_wb_engid == ENGID_W'(e));

    stk_rsp_slot #(
      .OPCODE_W (OPCODE_W),
      .DAT_W    (DAT_W),
      .OP_NOP   (OP_NOP),
      .OP_POP   (OP_POP)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .wb_sel    (wb_sel[e]),
      .wb_opcode (i_wb_opcode),
      .wb_status (i_wb_status),
      .wb_dat    (i_wb_dat),
      .ack       (i_rsp_ack[e]),
      .vld       (o_rsp_vld[e]),
      .opcode    (o_rsp_opcode[e]),
      .status    (o_rsp_status[e]),
      .dat       (o_rsp_dat[e]),
      .ad_pulse  (o_ad_rsp_vld[e]),
      .inc       (inc[e]),
      .dec       (dec[e]),
      .ovf       (ovf[e])
    );
  end

  // inc/dec are exclusive per slot, so the count stays within 0..ENGS_N
  always_comb begin
    cnt_nxt = o_pend_cnt;
    for (int e = 0; e < ENGS_N; e++) begin
      if (inc[e]) cnt_nxt = cnt_nxt + CNT_W'(1);
      if (dec[e]) cnt_nxt = cnt_nxt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_pend_cnt <= '0;
      o_err_ovf  <= 1'b0;
      o_err_op   <= 1'b0;
    end else begin
      o_pend_cnt <= cnt_nxt;
      if (|ovf)                o_err_ovf <= 1'b1;
      if (i_wb_vld & ~op_ok)   o_err_op  <= 1'b1;
    end
  end
endmodule
